// File: rtl/adc_capture_writer.sv
// Captures a triggered, decimated ADC burst and writes tagged 32-bit words into the meas or offs RAM.
// Latency: a kept sample in cycle N appears as a RAM write (we/adr/dat) in cycle N+1; done_o follows the last write by one cycle.
// Backpressure: none; the ADC stream and RAM write port are never stalled, and samples outside CAPTURE are dropped.
module adc_capture_writer #(
    parameter int g_adc_width  = 16,
    parameter int g_depth_log2 = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    trig_i,
    input  logic                    target_i,
    input  logic [7:0]              decim_i,
    input  logic [12:0]             nsamples_i,
    input  logic [1:0]              cal_sel_i,
    input  logic                    adc_valid_i,
    input  logic [g_adc_width-1:0]  adc_data_i,
    output logic [g_depth_log2-1:0] adc_meas_adr_o,
    output logic                    adc_meas_data_we_o,
    output logic [31:0]             adc_meas_data_dat_o,
    output logic [g_depth_log2-1:0] adc_offs_adr_o,
    output logic                    adc_offs_data_we_o,
    output logic [31:0]             adc_offs_data_dat_o,
    output logic                    busy_o,
    output logic                    armed_o,
    output logic                    done_o,
    output logic [12:0]             count_o
);

    localparam logic [12:0] c_depth = 13'(2 ** g_depth_log2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    target_q, target_d;
    logic [7:0]              decim_q, decim_d;
    logic [12:0]             nsamples_q, nsamples_d;
    logic [7:0]              dec_q, dec_d;
    logic [12:0]             count_q, count_d;
    logic [7:0]              run_q, run_d;
    logic                    meas_we_q, meas_we_d;
    logic                    offs_we_q, offs_we_d;
    logic [g_depth_log2-1:0] adr_q, adr_d;
    logic [31:0]             dat_q, dat_d;
    logic                    busy_q, busy_d;
    logic                    armed_q, armed_d;
    logic                    done_q, done_d;

    logic                    keep;
    logic [12:0]             ns_clamped;
    logic [15:0]             sample_sext;

    // Next-state, decimation, write-path and status computation; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        decim_d     = decim_q;
        nsamples_d  = nsamples_q;
        dec_d       = dec_q;
        count_d     = count_q;
        run_d       = run_q;
        meas_we_d   = 1'b0;
        offs_we_d   = 1'b0;
        adr_d       = adr_q;
        dat_d       = dat_q;
        done_d      = 1'b0;
        keep        = 1'b0;
        ns_clamped  = (nsamples_i > c_depth) ? c_depth : nsamples_i;
        sample_sext = 16'($signed(adc_data_i));

        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        target_d   = target_i;
                        decim_d    = decim_i;
                        nsamples_d = ns_clamped;
                        count_d    = 13'd0;
                        dec_d      = 8'd0;
                        state_d    = (ns_clamped == 13'd0) ? S_DONE : S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trig_i) begin
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (adc_valid_i) begin
                        if (dec_q == 8'd0) begin
                            keep  = 1'b1;
                            dec_d = decim_q;
                        end else begin
                            dec_d = dec_q - 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    run_d   = run_q + 8'd1;
                end
                default: state_d = S_IDLE;
            endcase

            // The address is the pre-increment count, so the first word lands at 0.
            if (keep) begin
                meas_we_d = ~target_q;
                offs_we_d = target_q;
                adr_d     = count_q[g_depth_log2-1:0];
                dat_d     = {run_q, 6'b0, cal_sel_i, sample_sext};
                count_d   = count_q + 13'd1;
                if (count_q + 13'd1 == nsamples_q) begin
                    state_d = S_DONE;
                end
            end
        end

        busy_d  = (state_d == S_ARMED) || (state_d == S_CAPTURE);
        armed_d = (state_d == S_ARMED);
    end

    // State, configuration and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            target_q   <= 1'b0;
            decim_q    <= 8'd0;
            nsamples_q <= 13'd0;
            dec_q      <= 8'd0;
            count_q    <= 13'd0;
            run_q      <= 8'd0;
            meas_we_q  <= 1'b0;
            offs_we_q  <= 1'b0;
            adr_q      <= '0;
            dat_q      <= 32'd0;
            busy_q     <= 1'b0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            decim_q    <= decim_d;
            nsamples_q <= nsamples_d;
            dec_q      <= dec_d;
            count_q    <= count_d;
            run_q      <= run_d;
            meas_we_q  <= meas_we_d;
            offs_we_q  <= offs_we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
            armed_q    <= armed_d;
            done_q     <= done_d;
        end
    end

    assign adc_meas_adr_o      = adr_q;
    assign adc_meas_data_we_o  = meas_we_q;
    assign adc_meas_data_dat_o = dat_q;
    assign adc_offs_adr_o      = adr_q;
    assign adc_offs_data_we_o  = offs_we_q;
    assign adc_offs_data_dat_o = dat_q;
    assign busy_o              = busy_q;
    assign armed_o             = armed_q;
    assign done_o              = done_q;
    assign count_o             = count_q;

endmodule

// File: tb/tb_adc_capture_writer.sv
// Directed bench for adc_capture_writer: vector table for the basic run, hand sequences for corner cases.
// Latency: outputs are sampled 1 time unit after each rising edge, inputs driven right after sampling.
// Backpressure: none exercised; every wait on the DUT is bounded by a cycle budget.
module tb_adc_capture_writer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i, abort_i, trig_i, target_i;
    logic [7:0]  decim_i;
    logic [12:0] nsamples_i;
    logic [1:0]  cal_sel_i;
    logic        adc_valid_i;
    logic [11:0] adc_data_i;
    logic [11:0] adc_meas_adr_o, adc_offs_adr_o;
    logic        adc_meas_data_we_o, adc_offs_data_we_o;
    logic [31:0] adc_meas_data_dat_o, adc_offs_data_dat_o;
    logic        busy_o, armed_o, done_o;
    logic [12:0] count_o;

    int n_cmp = 0;
    int n_bad = 0;

    adc_capture_writer #(.g_adc_width(12), .g_depth_log2(12)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
        .trig_i(trig_i), .target_i(target_i), .decim_i(decim_i), .nsamples_i(nsamples_i),
        .cal_sel_i(cal_sel_i), .adc_valid_i(adc_valid_i), .adc_data_i(adc_data_i),
        .adc_meas_adr_o(adc_meas_adr_o), .adc_meas_data_we_o(adc_meas_data_we_o),
        .adc_meas_data_dat_o(adc_meas_data_dat_o), .adc_offs_adr_o(adc_offs_adr_o),
        .adc_offs_data_we_o(adc_offs_data_we_o), .adc_offs_data_dat_o(adc_offs_data_dat_o),
        .busy_o(busy_o), .armed_o(armed_o), .done_o(done_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        start, trig, target, vld;
        logic [7:0]  decim;
        logic [12:0] ns;
        logic [1:0]  cal;
        logic [11:0] data;
        logic        e_mwe, e_owe, e_busy, e_armed, e_done;
        logic [11:0] e_adr;
        logic [31:0] e_dat;
        logic [12:0] e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        start_i = 0; abort_i = 0; trig_i = 0; target_i = 0; decim_i = 0;
        nsamples_i = 0; cal_sel_i = 0; adc_valid_i = 0; adc_data_i = 0;
    endtask

    function automatic vec_t mk(input logic st, input logic tr, input logic tg, input logic [7:0] dc,
                                input logic [12:0] ns, input logic [1:0] cal, input logic vld,
                                input logic [11:0] dat, input logic mwe, input logic owe,
                                input logic bsy, input logic arm, input logic dn,
                                input logic [11:0] eadr, input logic [31:0] edat, input logic [12:0] ecnt);
        vec_t v;
        v.start = st; v.trig = tr; v.target = tg; v.decim = dc; v.ns = ns; v.cal = cal;
        v.vld = vld; v.data = dat; v.e_mwe = mwe; v.e_owe = owe; v.e_busy = bsy;
        v.e_armed = arm; v.e_done = dn; v.e_adr = eadr; v.e_dat = edat; v.e_cnt = ecnt;
        return v;
    endfunction

    // Time-limit guard so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int wcnt, dcnt, mcnt, adr_err, last_adr, cyc;
        logic [31:0] first_dat;
        logic [11:0] dseq[9];
        logic [31:0] dexp[3];

        // Basic run: start/trig, six samples, four kept writes to meas RAM.
        tbl[0] = mk(1, 0, 0, 0, 4, 0, 0, 12'h000, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[1] = mk(0, 1, 0, 0, 0, 0, 0, 12'h000, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[2] = mk(0, 0, 0, 0, 0, 2, 1, 12'h001, 1, 0, 1, 0, 0, 0, 32'h0002_0001, 1);
        tbl[3] = mk(0, 0, 0, 0, 0, 2, 1, 12'h002, 1, 0, 1, 0, 0, 1, 32'h0002_0002, 2);
        tbl[4] = mk(0, 0, 0, 0, 0, 2, 1, 12'h003, 1, 0, 1, 0, 0, 2, 32'h0002_0003, 3);
        tbl[5] = mk(0, 0, 0, 0, 0, 2, 1, 12'h004, 1, 0, 0, 0, 0, 3, 32'h0002_0004, 4);
        tbl[6] = mk(0, 0, 0, 0, 0, 2, 1, 12'h005, 0, 0, 0, 0, 1, 0, 0, 4);
        tbl[7] = mk(0, 0, 0, 0, 0, 2, 1, 12'h006, 0, 0, 0, 0, 0, 0, 0, 4);

        idle_in();
        rst_n_i = 0;
        repeat (3) tick();
        chk("rst_mwe", adc_meas_data_we_o, 0);
        chk("rst_owe", adc_offs_data_we_o, 0);
        chk("rst_adr", adc_meas_adr_o, 0);
        chk("rst_dat", adc_meas_data_dat_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_armed", armed_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_count", count_o, 0);
        rst_n_i = 1;
        tick();

        for (int i = 0; i < 8; i++) begin
            start_i = tbl[i].start; trig_i = tbl[i].trig; target_i = tbl[i].target;
            decim_i = tbl[i].decim; nsamples_i = tbl[i].ns; cal_sel_i = tbl[i].cal;
            adc_valid_i = tbl[i].vld; adc_data_i = tbl[i].data;
            tick();
            chk($sformatf("v%0d_mwe", i), adc_meas_data_we_o, tbl[i].e_mwe);
            chk($sformatf("v%0d_owe", i), adc_offs_data_we_o, tbl[i].e_owe);
            chk($sformatf("v%0d_busy", i), busy_o, tbl[i].e_busy);
            chk($sformatf("v%0d_armed", i), armed_o, tbl[i].e_armed);
            chk($sformatf("v%0d_done", i), done_o, tbl[i].e_done);
            chk($sformatf("v%0d_count", i), count_o, tbl[i].e_cnt);
            if (tbl[i].e_mwe) begin
                chk($sformatf("v%0d_adr", i), adc_meas_adr_o, tbl[i].e_adr);
                chk($sformatf("v%0d_dat", i), adc_meas_data_dat_o, tbl[i].e_dat);
            end
        end
        idle_in();

        // Decimation by 3 into offs RAM with sign extension; second run tag.
        dseq = '{12'h800, 12'h111, 12'h222, 12'h7FF, 12'h333, 12'h444, 12'h123, 12'h555, 12'h666};
        dexp = '{32'h0101_F800, 32'h0101_07FF, 32'h0101_0123};
        start_i = 1; target_i = 1; decim_i = 2; nsamples_i = 3;
        tick();
        idle_in();
        trig_i = 1;
        tick();
        idle_in();
        wcnt = 0; dcnt = 0; mcnt = 0;
        for (int k = 0; k < 11; k++) begin
            adc_valid_i = (k < 9); adc_data_i = (k < 9) ? dseq[k] : 12'h0; cal_sel_i = 1;
            tick();
            if (adc_meas_data_we_o) mcnt++;
            if (done_o) dcnt++;
            if (adc_offs_data_we_o) begin
                if (wcnt < 3) begin
                    chk($sformatf("dec_adr%0d", wcnt), adc_offs_adr_o, wcnt);
                    chk($sformatf("dec_dat%0d", wcnt), adc_offs_data_dat_o, dexp[wcnt]);
                end
                wcnt++;
            end
        end
        idle_in();
        chk("dec_writes", wcnt, 3);
        chk("dec_meas_we", mcnt, 0);
        chk("dec_done", dcnt, 1);
        chk("dec_count", count_o, 3);

        // Full depth: 8191 clamps to 4096 writes, no address wrap.
        start_i = 1; target_i = 0; decim_i = 0; nsamples_i = 13'd8191;
        tick();
        idle_in();
        trig_i = 1;
        tick();
        idle_in();
        wcnt = 0; dcnt = 0; mcnt = 0; adr_err = 0; last_adr = -1; first_dat = 32'hFFFF_FFFF;
        cyc = 0;
        while (dcnt == 0 && cyc < 5000) begin
            adc_valid_i = 1; adc_data_i = 12'(wcnt);
            tick();
            cyc++;
            if (adc_offs_data_we_o) mcnt++;
            if (done_o) dcnt++;
            if (adc_meas_data_we_o) begin
                if (wcnt == 0) first_dat = adc_meas_data_dat_o;
                if (int'(adc_meas_adr_o) != (wcnt % 4096)) adr_err++;
                last_adr = int'(adc_meas_adr_o);
                wcnt++;
            end
        end
        idle_in();
        chk("full_done_seen", dcnt, 1);
        chk("full_writes", wcnt, 4096);
        chk("full_last_adr", last_adr, 32'hFFF);
        chk("full_adr_seq_err", adr_err, 0);
        chk("full_first_dat", first_dat, 32'h0200_0000);
        chk("full_offs_we", mcnt, 0);
        chk("full_count", count_o, 4096);

        // Pre-trigger: samples dropped while armed, second start ignored.
        start_i = 1; target_i = 1; nsamples_i = 2;
        tick();
        idle_in();
        wcnt = 0;
        for (int k = 0; k < 5; k++) begin
            adc_valid_i = 1; adc_data_i = 12'h0AA;
            tick();
            if (adc_meas_data_we_o || adc_offs_data_we_o || !armed_o) wcnt++;
        end
        chk("pre_no_write_armed", wcnt, 0);
        idle_in();
        start_i = 1; target_i = 0; nsamples_i = 5;
        tick();
        idle_in();
        chk("pre_restart_armed", armed_o, 1);
        chk("pre_restart_count", count_o, 0);
        trig_i = 1;
        tick();
        idle_in();
        wcnt = 0; mcnt = 0; dcnt = 0;
        for (int k = 0; k < 5; k++) begin
            adc_valid_i = 1; adc_data_i = 12'(k + 1);
            tick();
            if (adc_offs_data_we_o) wcnt++;
            if (adc_meas_data_we_o) mcnt++;
            if (done_o) dcnt++;
        end
        idle_in();
        chk("pre_offs_writes", wcnt, 2);
        chk("pre_meas_writes", mcnt, 0);
        chk("pre_done", dcnt, 1);
        chk("pre_count", count_o, 2);

        // Abort after 2 of 10 words.
        start_i = 1; target_i = 0; nsamples_i = 10;
        tick();
        idle_in();
        trig_i = 1;
        tick();
        idle_in();
        for (int k = 0; k < 2; k++) begin
            adc_valid_i = 1; adc_data_i = 12'(k);
            tick();
        end
        chk("abt_pre_count", count_o, 2);
        abort_i = 1; adc_valid_i = 1; adc_data_i = 12'h3;
        tick();
        idle_in();
        chk("abt_busy", busy_o, 0);
        chk("abt_we", adc_meas_data_we_o, 0);
        chk("abt_count", count_o, 2);
        dcnt = 0;
        for (int k = 0; k < 3; k++) begin
            adc_valid_i = 1;
            tick();
            if (done_o) dcnt++;
        end
        idle_in();
        chk("abt_no_done", dcnt, 0);
        start_i = 1; nsamples_i = 10;
        tick();
        idle_in();
        chk("abt_restart_count", count_o, 0);
        chk("abt_restart_armed", armed_o, 1);
        abort_i = 1; start_i = 1; trig_i = 1; nsamples_i = 4;
        tick();
        idle_in();
        chk("abt_prio_busy", busy_o, 0);
        chk("abt_prio_armed", armed_o, 0);

        // Zero-length run: done two cycles after start, no write.
        start_i = 1; nsamples_i = 0;
        tick();
        idle_in();
        chk("zero_c1_done", done_o, 0);
        chk("zero_c1_busy", busy_o, 0);
        tick();
        chk("zero_c2_done", done_o, 1);
        chk("zero_c2_we", adc_meas_data_we_o | adc_offs_data_we_o, 0);
        tick();
        chk("zero_c3_done", done_o, 0);

        // Reset during capture clears every output on the next edge.
        start_i = 1; target_i = 1; nsamples_i = 5; cal_sel_i = 3;
        tick();
        idle_in();
        trig_i = 1;
        tick();
        idle_in();
        adc_valid_i = 1; adc_data_i = 12'h055; cal_sel_i = 3;
        tick();
        tick();
        chk("mid_pre_count", count_o, 2);
        rst_n_i = 0;
        tick();
        chk("mid_rst_owe", adc_offs_data_we_o, 0);
        chk("mid_rst_adr", adc_offs_adr_o, 0);
        chk("mid_rst_dat", adc_offs_data_dat_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_count", count_o, 0);
        rst_n_i = 1;
        idle_in();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_capture_writer.md
Name: adc_capture_writer

Overview:
- Upstream producer for the CSR block's two ADC RAMs (adc_offs, adc_meas, 4096 x 32 each).
- Takes a streaming ADC sample port and captures a triggered, decimated burst of samples.
- Formats each kept sample into a 32-bit tagged word and drives the external write port of the selected RAM.
- Sequenced by software-visible control strobes; reports busy/armed/done/count for status registers.

Parameters:
g_adc_width, 16, ADC sample width in bits, legal 8..16, sample treated as two's complement.
g_depth_log2, 12, RAM address width; depth = 2**g_depth_log2.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  synchronous active-low reset
start_i  in  1  one-cycle pulse: latch config, arm capture
abort_i  in  1  one-cycle pulse: return to IDLE from any state
trig_i  in  1  capture trigger, level-sampled while ARMED
target_i  in  1  0 = adc_meas RAM, 1 = adc_offs RAM; latched at start
decim_i  in  8  keep 1 of (decim_i+1) valid samples; latched at start
nsamples_i  in  13  words to write, 0..8191; latched at start
cal_sel_i  in  2  calibrator select, sampled with each kept sample
adc_valid_i  in  1  sample strobe
adc_data_i  in  g_adc_width  sample
adc_meas_adr_o  out  g_depth_log2  write address, meas RAM
adc_meas_data_we_o  out  1  write enable, meas RAM
adc_meas_data_dat_o  out  32  write data, meas RAM
adc_offs_adr_o  out  g_depth_log2  write address, offs RAM
adc_offs_data_we_o  out  1  write enable, offs RAM
adc_offs_data_dat_o  out  32  write data, offs RAM
busy_o  out  1  high in ARMED or CAPTURE
armed_o  out  1  high in ARMED
done_o  out  1  one-cycle pulse on capture completion
count_o  out  13  words written in current/last run

Behaviour:
Clock and reset:
- Single clock domain, clk_i.
- Reset is synchronous, active-low, on rst_n_i.
- Reset forces IDLE and clears every output: we, adr, dat, busy_o, armed_o, done_o, count_o all 0.
- Reset also clears the internal run counter, decimation counter and latched config.

State machine IDLE -> ARMED -> CAPTURE -> DONE -> IDLE:
- IDLE: start_i latches target, decim, nsamples.
  - Clamp: nsamples > 2**g_depth_log2 is clamped to 2**g_depth_log2.
  - Clears count_o and the decimation counter, then goes to ARMED.
  - If the clamped nsamples is 0: go straight to DONE and emit no write.
- ARMED: trig_i = 1 -> CAPTURE. Samples arriving while ARMED are discarded.
- CAPTURE: the first eligible sample is the first adc_valid_i in the cycle after trig_i was seen.
  - On each adc_valid_i: if the decimation counter is 0, keep the sample and reload the counter with decim; otherwise decrement.
  - When count reaches nsamples on a kept sample -> DONE.
- DONE: one cycle; done_o = 1; run counter increments by 1 (mod 256); then IDLE.
- start_i outside IDLE is ignored.
- abort_i has priority over every other event. Next state is IDLE, busy_o = 0, no done_o. A write already registered completes; count_o holds its value.
- start_i, trig_i and abort_i in the same cycle: abort wins.

Write path (registered):
- A kept sample in cycle N gives we = 1 in cycle N+1 on the selected RAM port only; the other port's we stays 0.
- adr = count value before increment, so the first word is written at address 0.
- count_o increments in cycle N+1.
- Back-to-back valid samples with decim = 0 produce one write per cycle.
- Address never wraps: the capture ends when count = nsamples, which is at most the depth.
- dat format: [31:24] = run counter; [23:18] = 0; [17:16] = cal_sel_i; [15:0] = adc_data_i sign-extended to 16 bits.
- adr/dat hold their last value when we = 0. Both RAM ports share the same adr/dat registers.

Status:
- busy_o and armed_o are registered from the state and track it with no extra latency.
- done_o is asserted exactly one cycle per completed run.

Test Plan:
- Basic run: reset; start with target=0, decim=0, nsamples=4; trig; 6 consecutive valid samples 0x0001..0x0006 with cal_sel=2 -> meas we on 4 cycles; adr 0..3; dat 0x00020001..0x00020004; done_o once; count_o=4; offs we never high.
- Decimation and sign extension: g_adc_width=12, decim=2, nsamples=3, target=1; 9 valid samples, first = 0x800 -> offs writes of samples 1,4,7; first dat[15:0]=0xF800; dat[31:24]=0x01 (second run).
- Full depth and clamp: nsamples=8191 -> exactly 4096 writes, last adr=0xFFF; count_o=4096; no address wrap.
- Pre-trigger behaviour: start then valid samples with no trig -> no writes, armed_o=1; a second start_i is ignored; trig then resumes normal capture.
- Abort mid-capture: abort_i after 2 of 10 words -> IDLE next cycle, busy_o=0, no done_o, count_o=2; a new start clears count_o to 0.
- Zero-length and reset mid-run: nsamples=0 -> done_o two cycles after start with no write; rst_n_i low during CAPTURE -> all outputs 0 on the next edge.
